// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset PC and the fetch-buffer entry record.
package fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_3000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction memory port, redirect input, instruction output.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect_valid, redirect_target, instr_ready
  );

  // memory / downstream side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect_valid, redirect_target, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry in-order instruction buffer; head is always a register.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = PC_RESET
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);
  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  // Next-state: flush beats everything; pop shifts tail into head so
  // the head only changes when it is consumed or the buffer was empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) head_d = push_data_i;
          else                 tail_d = push_data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = push_data_i;
          end else begin
            head_d = tail_q;
            tail_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage registers; head resets to the reset PC with a zero word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q.pc    <= RESET_PC;
      head_q.instr <= '0;
      tail_q       <= '0;
      count_q      <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, request credit, redirect squash.
module fetch_unit #(
  parameter logic [31:0] PC_RESET  = fetch_unit_pkg::PC_RESET,
  parameter int          BUF_DEPTH = 2   // only 2 is supported
) (
  input  logic clk,
  input  logic reset,
  fetch_unit_if.master bus
);
  import fetch_unit_pkg::*;

  localparam logic [2:0] CREDITS = 3'(BUF_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;   // PC of the request now in flight
  logic            inflight_q, inflight_d;

  logic         pop, push, issue;
  logic [1:0]   count;
  logic [2:0]   pending;
  fetch_entry_t push_entry, head;

  assign pop  = (count != 2'd0) & bus.instr_ready;
  // A response landing in a redirect cycle belongs to the old stream.
  assign push = inflight_q & ~bus.redirect_valid;

  // Slots already committed after this cycle's pop; request only if one is free.
  assign pending = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = reset & ~bus.redirect_valid & (pending < CREDITS);

  assign push_entry = '{pc: resp_pc_q, instr: bus.imem_rdata};

  // PC / in-flight next state: redirect overrides, otherwise advance on issue.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = issue;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_target & ~32'd3;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      resp_pc_d  = fetch_pc_q;
    end
  end

  // PC and credit state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= PC_RESET;
      resp_pc_q  <= PC_RESET;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(.RESET_PC(PC_RESET)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .flush_i    (bus.redirect_valid),
    .count_o    (count),
    .head_o     (head)
  );

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 32'h0000_3000, giving the PC of the first fetched instruction.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, giving the number of instruction buffer entries; only 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request strobe to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address, valid when imem_req=1.
REQ-007 imem_rdata  input  32  instruction word, valid exactly 1 cycle after the request.
REQ-008 redirect_valid  input  1  taken branch or jump from the downstream control/datapath stage.
REQ-009 redirect_target  input  32  new PC; bits [1:0] ignored.
REQ-010 instr_valid  output  1  instr and instr_pc hold a valid fetched instruction.
REQ-011 instr_ready  input  1  downstream accepts the instruction this cycle.
REQ-012 instr  output  32  fetched instruction word.
REQ-013 instr_pc  output  32  PC of instr; the consumer uses it for PC+4 and link values.

Function
REQ-014 The block SHALL hold fetch_pc; each issued request SHALL use imem_addr=fetch_pc, and fetch_pc SHALL advance by 4 on the same edge, wrapping modulo 2^32.
REQ-015 A request SHALL be issued when (count + inflight - pop) < 2, with no redirect that cycle. count = buffer occupancy; inflight = request issued the previous cycle; pop = instr_valid & instr_ready.
REQ-016 The response arriving the cycle after a request SHALL be written into the buffer at that cycle's end with its PC, unless it has been squashed.
REQ-017 Timing SHALL be: request in cycle N, rdata in N+1, instr_valid in N+2 at the earliest.
REQ-018 Sustained throughput SHALL be one instruction per cycle while instr_ready=1.
REQ-019 instr, instr_pc and instr_valid SHALL come from the buffer head, driven from registers, with no combinational path from imem_rdata.
REQ-020 instr and instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-021 Entries SHALL leave the buffer in fetch order, with no loss or duplication.
REQ-022 When redirect_valid=1 the block SHALL:
- set fetch_pc to {redirect_target[31:2],2'b00};
- clear the buffer;
- squash any in-flight response;
- issue no request that cycle.
REQ-023 If redirect coincides with pop, redirect SHALL win; the popped entry is still consumed, and instr_valid=0 in the next cycle.
REQ-024 If redirect coincides with an arriving response, that response SHALL be discarded.
REQ-025 The first post-redirect request SHALL occur the cycle after the redirect, so the target instruction reaches instr_valid 3 cycles after redirect_valid.
REQ-026 When the buffer is full, no request SHALL be issued and fetch_pc SHALL hold.
REQ-027 When the buffer is empty, instr_valid SHALL be 0.
REQ-028 Back-to-back redirects on consecutive cycles SHALL each take effect; only the last target is fetched.

Reset
REQ-029 Asserting reset (low) SHALL immediately set:
- fetch_pc=PC_RESET;
- count=0 and inflight=0;
- imem_req=0, instr_valid=0;
- instr=0, instr_pc=PC_RESET.
REQ-030 The first request SHALL issue on the first rising edge after reset deasserts, with imem_addr=PC_RESET.
REQ-031 Reset asserted mid-operation SHALL discard buffered and in-flight instructions, and the response due after reset releases SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold:
- PC_RESET;
- the 32-bit instruction/address width constants;
- a fetch-entry record type {pc[31:0], instr[31:0]}.
REQ-033 The 2-entry buffer SHALL be a separate sub-module fetch_fifo with push/pop/flush, count, and head outputs.
REQ-034 All PC, squash and credit logic SHALL live in fetch_unit.

Verification
REQ-035 Reset release, instr_ready=1, memory returns addr^32'hFFFF_FFFF -> instr_pc = 0x3000, 0x3004, 0x3008 on consecutive cycles starting 2 cycles after the first request.
REQ-036 instr_ready=0 for 5 cycles after valid -> exactly 2 entries held (0x3000, 0x3004), imem_req=0, outputs stable; on release, 0x3000 then 0x3004 then 0x3008 with no gap.
REQ-037 redirect_valid=1 with target 0x3043 while a response is in flight -> next instr_valid shows instr_pc=0x3040 3 cycles later; no 0x300x entry appears after the redirect.
REQ-038 Redirect plus pop in the same cycle, then another redirect to 0x3100 next cycle -> only 0x3100 emerges.
REQ-039 fetch_pc=0xFFFF_FFFC -> next request address is 0x0000_0000.
REQ-040 reset pulsed low for 1 cycle mid-stream with 2 entries buffered -> instr_valid drops immediately, and the first post-reset instruction has instr_pc=0x3000.
